// File: rtl/risc_pkg.sv
// Shared SimpleRISC definitions used by the memory-access stage.
//   NOP_INSN    : instruction word used for pipeline bubbles and reset
//   MEM_TIMEOUT : BUSY cycles allowed before a data-memory access is aborted
//   OP_*        : 5-bit opcodes (instruction bits [31:27])
//   mem_state_t : state of the data-memory handshake FSM
package risc_pkg;

  localparam logic [31:0] NOP_INSN    = 32'h6800_0000;
  localparam int          MEM_TIMEOUT = 64;

  localparam logic [4:0] OP_LD  = 5'b01110;
  localparam logic [4:0] OP_ST  = 5'b01111;
  localparam logic [4:0] OP_NOP = 5'b01101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/dmem_handshake.sv
// Data-memory handshake for the M stage.
// Handshake: dmem_req is a registered request held high for every BUSY
// cycle; the memory completes it by raising dmem_ready in one of those
// cycles (dmem_rdata valid in the same cycle). dmem_ready is ignored
// whenever dmem_req is low. dmem_we, dmem_addr and dmem_wdata qualify the
// request and stay stable while it is outstanding because E-M is frozen.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   is_ld, is_st        : memory-op controls from E-M
//   addr, wdata         : address and store data from E-M
//   dmem_*              : data-memory request/response
//   mem_stall           : freeze upstream while an op is pending
//   mem_error           : sticky timeout flag (cleared only by rst)
//   ld_data_q           : last captured load data (0 after a timeout)
//   mem_state           : FSM state, exposed for debug
module dmem_handshake
  import risc_pkg::*;
#(
  parameter int TIMEOUT = MEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_ld,
  input  logic        is_st,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        mem_stall,
  output logic        mem_error,
  output logic [31:0] ld_data_q,
  output mem_state_t  mem_state
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mem_state_t    state;
  logic [CW-1:0] cnt;
  logic          mem_op;

  assign mem_op     = is_ld | is_st;
  assign dmem_addr  = addr;
  assign dmem_wdata = wdata;
  assign mem_state  = state;

  // Stall is released in DONE so upstream advances on that edge and the
  // same op is never re-issued.
  assign mem_stall = ((state == IDLE) && mem_op) || (state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
      mem_error <= 1'b0;
      ld_data_q <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            state    <= BUSY;
            dmem_req <= 1'b1;
            // ld+st together is treated as a load
            dmem_we  <= is_st & ~is_ld;
            cnt      <= '0;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (dmem_ready) begin
            // Response data is captured for any completed op.
            ld_data_q <= dmem_rdata;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            state     <= DONE;
          end else if (cnt == CNT_LAST) begin
            mem_error <= 1'b1;
            ld_data_q <= '0;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/memory_access_cycle.sv
// Memory-access (M) stage of the SimpleRISC pipeline.
// Issues loads/stores through dmem_handshake, stalls upstream while an op is
// outstanding, provides forwarding values and registers the M-W buffer.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   *_M                           : E-M buffer contents and controls
//   dmem_*                        : data-memory request/response
//   mem_stall, mem_error          : hazard-unit stall, sticky timeout flag
//   data_M_out, memory_data_out   : forwarding values to execute
//   *_W                           : M-W buffer
//   mem_state                     : handshake FSM state, exposed for debug
module memory_access_cycle
  import risc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_M,
  input  logic [31:0] alu_result_M,
  input  logic [31:0] rd2_M,
  input  logic [31:0] instruction_M,
  input  logic        isLd_M,
  input  logic        isSt_M,
  input  logic        isWb_M,
  input  logic        isCall_M,
  input  logic [3:0]  RD_M,
  input  logic [3:0]  ra_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic        mem_error,
  output logic [31:0] data_M_out,
  output logic [31:0] memory_data_out,
  output logic [31:0] pc_W,
  output logic [31:0] alu_result_W,
  output logic [31:0] ld_result_W,
  output logic [31:0] instruction_W,
  output logic        isLd_W,
  output logic        isWb_W,
  output logic        isCall_W,
  output logic [3:0]  RD_W,
  output logic [3:0]  ra_W,
  output mem_state_t  mem_state
);

  logic [31:0] ld_data_q;

  dmem_handshake #(.TIMEOUT(MEM_TIMEOUT)) u_hs (
    .clk        (clk),
    .rst        (rst),
    .is_ld      (isLd_M),
    .is_st      (isSt_M),
    .addr       (alu_result_M),
    .wdata      (rd2_M),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .mem_stall  (mem_stall),
    .mem_error  (mem_error),
    .ld_data_q  (ld_data_q),
    .mem_state  (mem_state)
  );

  assign data_M_out      = alu_result_M;
  assign memory_data_out = ld_data_q;

  // M-W buffer: bubble while stalled, otherwise capture E-M. In DONE the
  // freshly captured load data is already in ld_data_q.
  always_ff @(posedge clk) begin
    if (rst || mem_stall) begin
      pc_W          <= '0;
      alu_result_W  <= '0;
      ld_result_W   <= '0;
      instruction_W <= NOP_INSN;
      isLd_W        <= 1'b0;
      isWb_W        <= 1'b0;
      isCall_W      <= 1'b0;
      RD_W          <= '0;
      ra_W          <= '0;
    end else begin
      pc_W          <= pc_M;
      alu_result_W  <= alu_result_M;
      ld_result_W   <= ld_data_q;
      instruction_W <= instruction_M;
      isLd_W        <= isLd_M;
      isWb_W        <= isWb_M;
      isCall_W      <= isCall_M;
      RD_W          <= RD_M;
      ra_W          <= ra_M;
    end
  end

endmodule
